// File: rtl/dso_pkg.sv
// Shared types for the oscilloscope capture path.
package dso_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_t;

    typedef enum logic [1:0] {
        TS_SPI   = 2'd0,
        TS_UART  = 2'd1,
        TS_CAN   = 2'd2,
        TS_FORCE = 2'd3
    } trig_src_t;

endpackage

// File: rtl/trig_edge_sel.sv
// Selects one protocol trigger and reports its rising edge while armed.
module trig_edge_sel
    import dso_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  trig_src_t i_src,
    input  logic      i_armed,
    input  logic      i_spi,
    input  logic      i_uart,
    input  logic      i_can,
    output logic      trig_evt
);

    logic w_sel;
    logic r_prev;

    // Source mux driven by the source latched at arm time.
    always_comb begin
        w_sel = 1'b0;
        unique case (i_src)
            TS_SPI:   w_sel = i_spi;
            TS_UART:  w_sel = i_uart;
            TS_CAN:   w_sel = i_can;
            TS_FORCE: w_sel = 1'b0;
        endcase
    end

    // Previous-value flop runs in every state so a level held across arming does not fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= w_sel;
    end

    assign trig_evt = i_armed & ((i_src == TS_FORCE) | (w_sel & ~r_prev));

endmodule

// File: rtl/capture_ctrl.sv
// Capture RAM write sequencer: pre-trigger fill, trigger wait, post-trigger fill, readout hold.
module capture_ctrl
    import dso_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_en,
    input  logic              run,
    input  logic              rd_ack,
    input  logic [1:0]        trig_src,
    input  logic              SPItrig,
    input  logic              UARTtrig,
    input  logic              CANtrig,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    cap_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
    logic [ADDR_W-1:0] r_trig_addr, w_trig_addr_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    trig_src_t         r_src;
    logic [ADDR_W-1:0] r_tpos;
    logic              r_armed, r_triggered, r_done;
    logic              w_we, w_load, w_trig_evt;
    logic [CNT_W-1:0]  w_cnt_inc, w_pre_tgt, w_post_tgt;

    // trig_pos is ADDR_W bits wide, so it can never exceed DEPTH-1 and needs no clamp logic.
    assign w_post_tgt = CNT_W'(r_tpos);
    assign w_pre_tgt  = CNT_W'(DEPTH) - w_post_tgt;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    trig_edge_sel u_trig_edge_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_src    (r_src),
        .i_armed  (r_state == ST_ARMED),
        .i_spi    (SPItrig),
        .i_uart   (UARTtrig),
        .i_can    (CANtrig),
        .trig_evt (w_trig_evt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, write strobe and address/counter updates.
    always_comb begin
        w_state_nxt     = r_state;
        w_waddr_nxt     = r_waddr;
        w_trig_addr_nxt = r_trig_addr;
        w_cnt_nxt       = r_cnt;
        w_we            = 1'b0;
        w_load          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_PRE;
                    w_waddr_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_PRE: begin
                if (cap_en) begin
                    w_we        = 1'b1;
                    w_waddr_nxt = r_waddr + ADDR_W'(1);
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == w_pre_tgt) w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cap_en) begin
                    w_we        = 1'b1;
                    w_waddr_nxt = r_waddr + ADDR_W'(1);
                end
                if (w_trig_evt) begin
                    // A same-cycle sample is still pre-trigger, so the window starts one later.
                    w_trig_addr_nxt = r_waddr + ADDR_W'(cap_en);
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_POST;
                end
            end
            ST_POST: begin
                if (r_tpos == '0) begin
                    w_state_nxt = ST_DONE;
                end else if (cap_en) begin
                    w_we        = 1'b1;
                    w_waddr_nxt = r_waddr + ADDR_W'(1);
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == w_post_tgt) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rd_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr     <= '0;
            r_trig_addr <= '0;
            r_cnt       <= '0;
            r_src       <= TS_SPI;
            r_tpos      <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_waddr     <= w_waddr_nxt;
            r_trig_addr <= w_trig_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_load) begin
                r_src  <= trig_src_t'(trig_src);
                r_tpos <= trig_pos;
            end
            r_armed     <= (w_state_nxt == ST_ARMED);
            r_triggered <= (w_state_nxt == ST_POST) || (w_state_nxt == ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign we           = w_we;
    assign waddr        = r_waddr;
    assign trig_addr    = r_trig_addr;
    assign armed        = r_armed;
    assign triggered    = r_triggered;
    assign capture_done = r_done;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a window-counting reference model.
module tb_capture_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MD_IDLE = 0, MD_PRE = 1, MD_ARMED = 2, MD_POST = 3, MD_DONE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap_en = 1'b0, run = 1'b0, rd_ack = 1'b0;
    logic [1:0]    trig_src = 2'd0;
    logic          SPItrig = 1'b0, UARTtrig = 1'b0, CANtrig = 1'b0;
    logic [AW-1:0] trig_pos = '0;
    logic          we, armed, triggered, capture_done;
    logic [AW-1:0] waddr, trig_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase plus remaining pre/post sample budgets.
    int m_mode, m_addr, m_taddr, m_pre_left, m_post_left, m_src, m_tpos;
    bit m_pspi, m_puart, m_pcan;

    capture_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cap_en       (cap_en),
        .run          (run),
        .rd_ack       (rd_ack),
        .trig_src     (trig_src),
        .SPItrig      (SPItrig),
        .UARTtrig     (UARTtrig),
        .CANtrig      (CANtrig),
        .trig_pos     (trig_pos),
        .we           (we),
        .waddr        (waddr),
        .trig_addr    (trig_addr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update, evaluated from the inputs present before each edge.
    always @(posedge clk or negedge rst_n) begin : model
        int  mode, addr, taddr, pre_left, post_left, src, tpos;
        bit  cur, prv, fire;
        if (!rst_n) begin
            m_mode <= MD_IDLE; m_addr <= 0; m_taddr <= 0;
            m_pre_left <= 0; m_post_left <= 0; m_src <= 0; m_tpos <= 0;
            m_pspi <= 1'b0; m_puart <= 1'b0; m_pcan <= 1'b0;
        end else begin
            mode = m_mode; addr = m_addr; taddr = m_taddr;
            pre_left = m_pre_left; post_left = m_post_left; src = m_src; tpos = m_tpos;
            case (mode)
                MD_IDLE: if (run) begin
                    mode = MD_PRE; addr = 0; src = int'(trig_src); tpos = int'(trig_pos);
                    pre_left = DEPTH - tpos;
                end
                MD_PRE: if (cap_en) begin
                    addr = (addr + 1) % DEPTH;
                    pre_left--;
                    if (pre_left == 0) mode = MD_ARMED;
                end
                MD_ARMED: begin
                    cur  = (src == 0) ? SPItrig : (src == 1) ? UARTtrig : CANtrig;
                    prv  = (src == 0) ? m_pspi  : (src == 1) ? m_puart  : m_pcan;
                    fire = (src == 3) || (cur && !prv);
                    if (cap_en) addr = (addr + 1) % DEPTH;
                    if (fire) begin
                        taddr = addr; post_left = tpos; mode = MD_POST;
                    end
                end
                MD_POST: begin
                    if (post_left == 0) mode = MD_DONE;
                    else if (cap_en) begin
                        addr = (addr + 1) % DEPTH;
                        post_left--;
                        if (post_left == 0) mode = MD_DONE;
                    end
                end
                default: if (rd_ack) mode = MD_IDLE;
            endcase
            m_mode <= mode; m_addr <= addr; m_taddr <= taddr;
            m_pre_left <= pre_left; m_post_left <= post_left; m_src <= src; m_tpos <= tpos;
            m_pspi <= SPItrig; m_puart <= UARTtrig; m_pcan <= CANtrig;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("we", int'(we), int'(cap_en && (m_mode == MD_PRE || m_mode == MD_ARMED ||
                                   (m_mode == MD_POST && m_post_left != 0))));
        check("waddr", int'(waddr), m_addr);
        check("trig_addr", int'(trig_addr), m_taddr);
        check("armed", int'(armed), int'(m_mode == MD_ARMED));
        check("triggered", int'(triggered), int'(m_mode == MD_POST || m_mode == MD_DONE));
        check("capture_done", int'(capture_done), int'(m_mode == MD_DONE));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1; tick(); run = 1'b0;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    endtask

    // Bounded waits: 0 = armed, 1 = triggered, 2 = capture_done.
    task automatic wait_flag(input int which, input int limit, input string name);
        int n = 0;
        while (!((which == 0 && armed) || (which == 1 && triggered) ||
                 (which == 2 && capture_done)) && n < limit) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, int'(n < limit), 1);
    endtask

    initial begin
        // Reset state with strobes present.
        cap_en = 1'b1;
        tick(); tick();
        check("rst_we", int'(we), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_flags", int'({armed, triggered, capture_done}), 0);
        rst_n = 1'b1;
        tick();

        // Basic capture: trig_pos 4, SPI trigger.
        trig_pos = 4'd4; trig_src = 2'd0;
        pulse_run();
        check("run_waddr", int'(waddr), 0);
        wait_flag(0, 40, "arm1");
        check("arm1_waddr", int'(waddr), 12);
        tick();
        SPItrig = 1'b1; tick(); SPItrig = 1'b0;
        check("t1_triggered", int'(triggered), 1);
        check("t1_trig_addr", int'(trig_addr), 14);
        check("t1_model_taddr", m_taddr, 14);
        repeat (4) tick();
        check("t1_done", int'(capture_done), 1);
        check("t1_final_waddr", int'(waddr), 2);

        // DONE ignores run and samples; rd_ack releases.
        run = 1'b1; #1;
        check("done_we", int'(we), 0);
        tick(); run = 1'b0; tick();
        check("done_hold", int'(capture_done), 1);
        check("done_waddr", int'(waddr), 2);
        pulse_ack();
        check("ack_done", int'(capture_done), 0);
        check("ack_trig", int'(triggered), 0);

        // UART selected; SPI and CAN activity must not trigger.
        trig_src = 2'd1;
        pulse_run();
        trig_src = 2'd0; trig_pos = 4'd9;
        wait_flag(0, 40, "arm2");
        for (int i = 0; i < 40; i++) begin
            SPItrig = (i % 2 == 0);
            CANtrig = (i % 3 == 0);
            tick();
        end
        SPItrig = 1'b0; CANtrig = 1'b0;
        check("t2_still_armed", int'(armed), 1);
        UARTtrig = 1'b1; tick(); UARTtrig = 1'b0;
        check("t2_triggered", int'(triggered), 1);
        wait_flag(2, 40, "done2");
        pulse_ack();

        // CAN held high from reset into ARMED must not fire.
        CANtrig = 1'b1; trig_src = 2'd2; trig_pos = 4'd6;
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        pulse_run();
        wait_flag(0, 40, "arm3");
        repeat (10) tick();
        check("t3_no_fire", int'(triggered), 0);
        CANtrig = 1'b0; tick(); tick();
        CANtrig = 1'b1; tick(); CANtrig = 1'b0;
        check("t3_edge_fire", int'(triggered), 1);
        wait_flag(2, 40, "done3");
        pulse_ack();

        // trig_pos 0 forced: full 16-sample pre window, empty post window.
        trig_src = 2'd3; trig_pos = 4'd0;
        pulse_run();
        wait_flag(1, 40, "trig4");
        check("t4_trig_addr", int'(trig_addr), 1);
        check("t4_waddr", int'(waddr), 1);
        check("t4_post_we", int'(we), 0);
        tick();
        check("t4_done", int'(capture_done), 1);
        check("t4_done_waddr", int'(waddr), 1);
        pulse_ack();

        // trig_pos all-ones: one pre sample, fifteen post samples.
        trig_pos = 4'hF;
        pulse_run();
        tick();
        check("t5_armed", int'(armed), 1);
        check("t5_arm_waddr", int'(waddr), 1);
        wait_flag(2, 40, "done5");
        check("t5_trig_addr", int'(trig_addr), 2);
        check("t5_waddr", int'(waddr), 1);
        pulse_ack();

        // Reset in the middle of the post window.
        trig_pos = 4'd8;
        pulse_run();
        wait_flag(1, 40, "trig6");
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we", int'(we), 0);
        check("rst_mid_waddr", int'(waddr), 0);
        check("rst_mid_taddr", int'(trig_addr), 0);
        check("rst_mid_flags", int'({armed, triggered, capture_done}), 0);
        #2 rst_n = 1'b1;
        tick();
        pulse_run();
        check("restart_waddr", int'(waddr), 0);
        check("restart_we", int'(we), 1);
        tick();
        check("restart_waddr1", int'(waddr), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
